// File: rtl/lrhls_moment_pkg.sv
// Shared widths and FSM state encoding for the LRHLS moment accumulator.
package lrhls_moment_pkg;

    // Stub coordinate width and stub-counter width.
    localparam int IN_W   = 18;
    localparam int CNT_W  = 8;

    // Derived widths: a full-precision product, and sums wide enough that
    // 2^CNT_W-1 maximum-valued terms can never wrap.
    localparam int PROD_W = 2 * IN_W;
    localparam int SUM_W  = IN_W + CNT_W;
    localparam int ACC_W  = PROD_W + CNT_W;

    // ACC: taking stubs; DRAIN: last stub still in the product stage;
    // HOLD: sums presented until downstream takes them.
    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage : lrhls_moment_pkg

// File: rtl/lrhls_moment_mul.sv
// Combinational unsigned IN_W x IN_W multiplier with a full-width result.
module lrhls_moment_mul #(
    parameter int IN_W   = 18,
    parameter int PROD_W = 2 * IN_W
) (
    input  logic [IN_W-1:0]   a,
    input  logic [IN_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    // Both operands are widened first so the product keeps every bit.
    assign p = PROD_W'(a) * PROD_W'(b);

endmodule : lrhls_moment_mul

// File: rtl/lrhls_moment_accumulator.sv
// Streaming per-track moment accumulator: sums x, y, x*x, x*y and the stub
// count over one track, then holds the result on a valid/ready output.
module lrhls_moment_accumulator #(
    parameter int  IN_W   = lrhls_moment_pkg::IN_W,
    parameter int  CNT_W  = lrhls_moment_pkg::CNT_W,
    localparam int PROD_W = 2 * IN_W,
    localparam int SUM_W  = IN_W + CNT_W,
    localparam int ACC_W  = PROD_W + CNT_W
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    // Stub input stream
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IN_W-1:0]   s_x,
    input  logic [IN_W-1:0]   s_y,
    input  logic              s_last,
    // Per-track sums output
    output logic              m_valid,
    input  logic              m_ready,
    output logic [SUM_W-1:0]  m_sum_x,
    output logic [SUM_W-1:0]  m_sum_y,
    output logic [ACC_W-1:0]  m_sum_xx,
    output logic [ACC_W-1:0]  m_sum_xy,
    output logic [CNT_W-1:0]  m_count,
    output logic              m_ovf
);

    import lrhls_moment_pkg::*;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_e              state_q, state_d;

    logic                accept;
    logic [PROD_W-1:0]   xx_prod;
    logic [PROD_W-1:0]   xy_prod;

    // Product stage
    logic                p_valid_q, p_valid_d;
    logic                p_last_q,  p_last_d;
    logic [IN_W-1:0]     p_x_q,     p_x_d;
    logic [IN_W-1:0]     p_y_q,     p_y_d;
    logic [PROD_W-1:0]   p_xx_q,    p_xx_d;
    logic [PROD_W-1:0]   p_xy_q,    p_xy_d;

    // Accumulate stage
    logic [SUM_W-1:0]    sum_x_q,   sum_x_d;
    logic [SUM_W-1:0]    sum_y_q,   sum_y_d;
    logic [ACC_W-1:0]    sum_xx_q,  sum_xx_d;
    logic [ACC_W-1:0]    sum_xy_q,  sum_xy_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic                ovf_q,     ovf_d;

    logic                count_full;
    logic                hold_done;

    // ------------------------------------------------------------------
    // Handshakes: both ready and valid are pure decodes of the state, so
    // neither depends combinationally on the opposite side's handshake.
    // ------------------------------------------------------------------
    assign s_ready    = (state_q == ST_ACC);
    assign m_valid    = (state_q == ST_HOLD);
    assign accept     = s_valid & s_ready;
    assign hold_done  = m_valid & m_ready;
    assign count_full = &count_q;

    // ------------------------------------------------------------------
    // Multipliers: x*x and x*y on the incoming stub
    // ------------------------------------------------------------------
    lrhls_moment_mul #(
        .IN_W   (IN_W),
        .PROD_W (PROD_W)
    ) u_mul_xx (
        .a (s_x),
        .b (s_x),
        .p (xx_prod)
    );

    lrhls_moment_mul #(
        .IN_W   (IN_W),
        .PROD_W (PROD_W)
    ) u_mul_xy (
        .a (s_x),
        .b (s_y),
        .p (xy_prod)
    );

    // Next-state decode for the track FSM.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_ACC: begin
                if (accept && s_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The last stub is always sitting in the product stage here,
                // so this leaves DRAIN after exactly one cycle.
                if (p_last_q) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_done) state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    // Product stage: capture the stub and its products on every accepted beat.
    always_comb begin
        p_valid_d = accept;
        p_last_d  = accept & s_last;
        p_x_d     = p_x_q;
        p_y_d     = p_y_q;
        p_xx_d    = p_xx_q;
        p_xy_d    = p_xy_q;
        if (accept) begin
            p_x_d  = s_x;
            p_y_d  = s_y;
            p_xx_d = xx_prod;
            p_xy_d = xy_prod;
        end
    end

    // Accumulate stage: add the staged beat unless the counter is full,
    // in which case the beat is dropped and the sticky overflow flag set.
    always_comb begin
        sum_x_d  = sum_x_q;
        sum_y_d  = sum_y_q;
        sum_xx_d = sum_xx_q;
        sum_xy_d = sum_xy_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (hold_done) begin
            // The sums have been consumed; start the next track from zero.
            sum_x_d  = '0;
            sum_y_d  = '0;
            sum_xx_d = '0;
            sum_xy_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else if (p_valid_q) begin
            if (!count_full) begin
                sum_x_d  = sum_x_q  + SUM_W'(p_x_q);
                sum_y_d  = sum_y_q  + SUM_W'(p_y_q);
                sum_xx_d = sum_xx_q + ACC_W'(p_xx_q);
                sum_xy_d = sum_xy_q + ACC_W'(p_xy_q);
                count_d  = count_q  + CNT_W'(1);
            end else begin
                ovf_d    = 1'b1;
            end
        end
    end

    // State, product and accumulator registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            // NOTE: the datapath registers are reset too, so a track aborted
            // by reset leaves nothing behind and the outputs read zero.
            state_q   <= ST_ACC;
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
            p_x_q     <= '0;
            p_y_q     <= '0;
            p_xx_q    <= '0;
            p_xy_q    <= '0;
            sum_x_q   <= '0;
            sum_y_q   <= '0;
            sum_xx_q  <= '0;
            sum_xy_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // the pre-edge values, so the stages update in lockstep.
            state_q   <= state_d;
            p_valid_q <= p_valid_d;
            p_last_q  <= p_last_d;
            p_x_q     <= p_x_d;
            p_y_q     <= p_y_d;
            p_xx_q    <= p_xx_d;
            p_xy_q    <= p_xy_d;
            sum_x_q   <= sum_x_d;
            sum_y_q   <= sum_y_d;
            sum_xx_q  <= sum_xx_d;
            sum_xy_q  <= sum_xy_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from the accumulator registers and therefore
    // stay stable for as long as the FSM sits in HOLD.
    // ------------------------------------------------------------------
    assign m_sum_x  = sum_x_q;
    assign m_sum_y  = sum_y_q;
    assign m_sum_xx = sum_xx_q;
    assign m_sum_xy = sum_xy_q;
    assign m_count  = count_q;
    assign m_ovf    = ovf_q;

endmodule : lrhls_moment_accumulator

// File: tb/tb_lrhls_moment_accumulator.sv
// Directed self-checking bench for lrhls_moment_accumulator.
module tb_lrhls_moment_accumulator;

    localparam int IN_W  = 18;
    localparam int CNT_W = 8;
    localparam int SUM_W = IN_W + CNT_W;
    localparam int ACC_W = 2 * IN_W + CNT_W;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [IN_W-1:0]   s_x;
    logic [IN_W-1:0]   s_y;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [SUM_W-1:0]  m_sum_x;
    logic [SUM_W-1:0]  m_sum_y;
    logic [ACC_W-1:0]  m_sum_xx;
    logic [ACC_W-1:0]  m_sum_xy;
    logic [CNT_W-1:0]  m_count;
    logic              m_ovf;

    int checks = 0;
    int errors = 0;

    lrhls_moment_accumulator dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_x      (s_x),
        .s_y      (s_y),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_sum_x  (m_sum_x),
        .m_sum_y  (m_sum_y),
        .m_sum_xx (m_sum_xx),
        .m_sum_xy (m_sum_xy),
        .m_count  (m_count),
        .m_ovf    (m_ovf)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Present one stub for one cycle (caller guarantees s_ready is high).
    task automatic beat(input logic [IN_W-1:0] x, input logic [IN_W-1:0] y, input logic last);
        s_valid = 1'b1;
        s_x     = x;
        s_y     = y;
        s_last  = last;
        step();
    endtask

    task automatic idle_in();
        s_valid = 1'b0;
        s_x     = '0;
        s_y     = '0;
        s_last  = 1'b0;
    endtask

    task automatic check_sums(input string tag, input logic [63:0] sx, input logic [63:0] sy,
                              input logic [63:0] sxx, input logic [63:0] sxy,
                              input logic [63:0] cnt, input logic [63:0] ovf);
        check({tag, ".m_valid"},  64'(m_valid),  64'd1);
        check({tag, ".sum_x"},    64'(m_sum_x),  sx);
        check({tag, ".sum_y"},    64'(m_sum_y),  sy);
        check({tag, ".sum_xx"},   64'(m_sum_xx), sxx);
        check({tag, ".sum_xy"},   64'(m_sum_xy), sxy);
        check({tag, ".count"},    64'(m_count),  cnt);
        check({tag, ".ovf"},      64'(m_ovf),    ovf);
    endtask

    initial begin
        // ---------------- reset state ----------------
        ap_rst_n = 1'b0;
        m_ready  = 1'b1;
        idle_in();
        step();
        step();
        check("rst.s_ready", 64'(s_ready), 64'd1);
        check("rst.m_valid", 64'(m_valid), 64'd0);
        check("rst.sum_x",   64'(m_sum_x), 64'd0);
        check("rst.count",   64'(m_count), 64'd0);
        check("rst.ovf",     64'(m_ovf),   64'd0);
        #2 ap_rst_n = 1'b1;
        step();

        // ---------------- basic three-stub track ----------------
        beat(18'd1, 18'd2, 1'b0);
        beat(18'd3, 18'd4, 1'b0);
        beat(18'd5, 18'd6, 1'b1);
        idle_in();
        check("basic.drain.s_ready", 64'(s_ready), 64'd0);
        check("basic.drain.m_valid", 64'(m_valid), 64'd0);
        step();
        check_sums("basic", 64'd9, 64'd12, 64'd35, 64'd44, 64'd3, 64'd0);
        step();
        check("basic.after.m_valid", 64'(m_valid), 64'd0);
        check("basic.after.s_ready", 64'(s_ready), 64'd1);
        check("basic.after.sum_x",   64'(m_sum_x), 64'd0);
        check("basic.after.count",   64'(m_count), 64'd0);

        // ---------------- back-to-back single-stub tracks ----------------
        beat(18'd7, 18'd3, 1'b1);
        // Next stub already presented; must be ignored while s_ready is low.
        s_x = 18'd2;
        s_y = 18'd9;
        check("b2b1.drain.s_ready", 64'(s_ready), 64'd0);
        step();
        check("b2b1.hold.s_ready", 64'(s_ready), 64'd0);
        check_sums("b2b1", 64'd7, 64'd3, 64'd49, 64'd21, 64'd1, 64'd0);
        step();
        check("b2b2.acc.s_ready", 64'(s_ready), 64'd1);
        check("b2b2.acc.sum_x",   64'(m_sum_x), 64'd0);
        step();
        check("b2b2.drain.s_ready", 64'(s_ready), 64'd0);
        idle_in();
        step();
        check("b2b2.hold.s_ready", 64'(s_ready), 64'd0);
        check_sums("b2b2", 64'd2, 64'd9, 64'd4, 64'd18, 64'd1, 64'd0);
        step();
        check("b2b2.after.s_ready", 64'(s_ready), 64'd1);

        // ---------------- maximum values, 255 stubs ----------------
        for (int i = 1; i <= 255; i++) begin
            beat(18'h3FFFF, 18'h3FFFF, (i == 255));
        end
        idle_in();
        step();
        check_sums("max", 64'd66846465, 64'd66846465, 64'd17523332874495,
                   64'd17523332874495, 64'd255, 64'd0);
        step();

        // ---------------- count overflow, 256 stubs ----------------
        for (int i = 1; i <= 256; i++) begin
            beat(18'd1, 18'd1, (i == 256));
        end
        idle_in();
        check("ovf.drain.s_ready", 64'(s_ready), 64'd0);
        step();
        check_sums("ovf", 64'd255, 64'd255, 64'd255, 64'd255, 64'd255, 64'd1);
        step();
        beat(18'd1, 18'd1, 1'b1);
        idle_in();
        step();
        check_sums("ovf.next", 64'd1, 64'd1, 64'd1, 64'd1, 64'd1, 64'd0);
        step();

        // ---------------- output backpressure ----------------
        m_ready = 1'b0;
        beat(18'd2, 18'd3, 1'b0);
        beat(18'd4, 18'd5, 1'b1);
        s_valid = 1'b1;
        s_x     = 18'd100;
        s_y     = 18'd100;
        s_last  = 1'b1;
        step();
        check_sums("bp.enter", 64'd6, 64'd8, 64'd20, 64'd26, 64'd2, 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp.hold.m_valid", 64'(m_valid),  64'd1);
            check("bp.hold.s_ready", 64'(s_ready),  64'd0);
            check("bp.hold.sum_x",   64'(m_sum_x),  64'd6);
            check("bp.hold.sum_xy",  64'(m_sum_xy), 64'd26);
            check("bp.hold.count",   64'(m_count),  64'd2);
        end
        idle_in();
        m_ready = 1'b1;
        step();
        check("bp.release.m_valid", 64'(m_valid), 64'd0);
        check("bp.release.s_ready", 64'(s_ready), 64'd1);
        check("bp.release.count",   64'(m_count), 64'd0);

        // ---------------- reset mid-track ----------------
        beat(18'd9, 18'd9, 1'b0);
        beat(18'd9, 18'd9, 1'b0);
        idle_in();
        #2 ap_rst_n = 1'b0;
        #1;
        check("midrst.s_ready", 64'(s_ready), 64'd1);
        check("midrst.m_valid", 64'(m_valid), 64'd0);
        check("midrst.sum_x",   64'(m_sum_x), 64'd0);
        check("midrst.count",   64'(m_count), 64'd0);
        step();
        #2 ap_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst.idle.m_valid", 64'(m_valid), 64'd0);
            check("midrst.idle.count",   64'(m_count), 64'd0);
        end
        beat(18'd4, 18'd5, 1'b1);
        idle_in();
        check("fresh.drain.m_valid", 64'(m_valid), 64'd0);
        step();
        check_sums("fresh", 64'd4, 64'd5, 64'd16, 64'd20, 64'd1, 64'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net: the directed sequence is bounded, but never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule : tb_lrhls_moment_accumulator
